// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/halt sequencer for the 5-stage pipeline with memory watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state, state_nx;
    logic [1:0]  drain_cnt;
    logic [7:0]  wait_cnt;
    logic        freeze, active, trip;
    logic [7:0]  ctl;

    assign freeze = mem_req & ~mem_ready;
    assign active = state != HALTED;
    assign trip   = active & freeze & (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign halted = state == HALTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= (active && freeze) ? wait_cnt + 8'd1 : 8'd0;
            drain_cnt <= (state == RUN) ? 2'd0 : (state == DRAIN && !freeze) ? drain_cnt + 2'd1 : drain_cnt;
            if (trip)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (trip)
            state_nx = HALTED;
        else if (!freeze && state == RUN && halt_req && !branch_taken && !load_use)
            state_nx = DRAIN;
        else if (!freeze && state == DRAIN && drain_cnt == 2'd2)
            state_nx = HALTED;
    end

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mem_wb_flush}
    always_comb begin
        ctl = (state == HALTED)    ? 8'b0000_0000 :
              freeze               ? 8'b0000_1001 :
              (state == DRAIN)     ? 8'b0111_1100 :
              branch_taken         ? 8'b1111_1110 :
              load_use             ? 8'b0011_1010 :
              halt_req             ? 8'b0111_1100 :
                                     8'b1111_1000;
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush} = ctl;

`ifdef PIPE_PERF_CNT_EN
    logic run_ok;
    assign run_ok = active && !freeze && state == RUN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= '0;
            mem_wait_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (active && freeze && !(&mem_wait_cnt))
                mem_wait_cnt <= mem_wait_cnt + 1'b1;
            if (run_ok && branch_taken && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
            if (run_ok && !branch_taken && load_use && !(&lu_stall_cnt))
                lu_stall_cnt <= lu_stall_cnt + 1'b1;
        end
    end
`else
    assign lu_stall_cnt = '0;
    assign mem_wait_cnt = '0;
    assign flush_cnt    = '0;
`endif
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Stall/flush sequencer for the 5-stage RISC-V pipeline. Combines three inputs into per-stage register enables, flushes and a halt status:
- the load-use stall from hazard detection,
- taken-branch redirects from EX,
- data-memory wait handshakes from MEM.

It also runs a halt FSM that drains the pipeline after an `ecall`/`ebreak`, and a memory-timeout watchdog. It sits beside the hazard detection logic and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- `MEM_TIMEOUT`, 16: consecutive memory-wait cycles (2..255) that trip the watchdog.
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_use` in 1: load-use stall request for the instruction in ID.
- `branch_taken` in 1: EX resolved a taken branch or jump.
- `halt_req` in 1: ID holds `ecall`/`ebreak`.
- `mem_req` in 1: MEM stage holds a load/store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: pipeline register write enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load a bubble (NOP, control bits zero).
- `halted` out 1: pipeline drained and stopped.
- `mem_err` out 1: watchdog tripped; sticky.
- `lu_stall_cnt`, `mem_wait_cnt`, `flush_cnt` out `CNT_W` each: performance counters.

## Operation
- `freeze` = `mem_req & ~mem_ready`. Per-cycle outputs are combinational from state and inputs. State, counters and error flags are registered.
- FSM states: RUN, DRAIN, HALTED. The flush and stall rows below apply only when `freeze`=0.
- **Default (RUN):**
  - All `*_en`=1, all flushes=0.
- **`freeze` (any non-HALTED state; overrides every other row):**
  - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`=0.
  - `mem_wb_en`=1 and `mem_wb_flush`=1, so WB receives a bubble.
  - The FSM holds state.
- **RUN, `branch_taken`:**
  - `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1.
  - `load_use` and `halt_req` are ignored that cycle.
- **RUN, `load_use` without branch:**
  - `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
  - `halt_req` is ignored that cycle.
- **RUN, `halt_req` without branch or load_use:**
  - `pc_en`=0, `if_id_flush`=1, `id_ex_en`=1.
  - Next state DRAIN, drain counter = 0.
- **DRAIN:**
  - `pc_en`=0, `if_id_flush`=1; ID/EX and later stages enabled; `branch_taken`, `load_use`, `halt_req` ignored.
  - The 2-bit drain counter increments on each non-freeze cycle.
  - The cycle the counter advances from 2 to 3 moves the FSM to HALTED, after `ecall` has passed EX, MEM and WB.
- **HALTED:**
  - All `*_en`=0, flushes=0, `halted`=1.
  - Inputs are ignored, including `freeze`.
  - Only `rst_n` exits.
- **Watchdog:**
  - `wait_cnt` (8-bit) increments on each freeze cycle and clears on any non-freeze cycle.
  - On the edge that ends the `MEM_TIMEOUT`-th consecutive freeze cycle, from RUN or DRAIN: `mem_err`←1 and state←HALTED.

## Timing
- Reset values:
  - state RUN, `wait_cnt`=0, drain counter=0, `mem_err`=0, `halted`=0, all counters 0.
  - Enables=1 and flushes=0 while in reset (RUN defaults).
- Reset asserted mid-wait or mid-drain: immediate return to RUN; `mem_err` clears.
- Zero-latency control: enables and flushes respond in the same cycle as their inputs.
- `halted` and `mem_err` rise one edge after the triggering condition.
- `mem_ready`=1 in the first MEM cycle means no freeze; `mem_ready` without `mem_req` is ignored.
- `halt_req` to `halted`=1: 4 edges with no freezes; each freeze cycle adds one.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `lu_stall_cnt` counts RUN cycles with `load_use` applied (not overridden).
  - `mem_wait_cnt` counts freeze cycles.
  - `flush_cnt` counts applied branch flushes.
  - Counters count only outside HALTED, saturate at all-ones and reset to 0.
- `PIPE_PERF_CNT_EN` undefined: the three counter ports remain and are tied to 0; no counter flops.

## Test plan
- `load_use`=1 for 1 cycle in RUN → that cycle `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; next cycle all defaults; `lu_stall_cnt`=1.
- `branch_taken`=1 with `load_use`=1 → `pc_en`=1, `if_id_flush`=`id_ex_flush`=1, `if_id_en`=1; `flush_cnt`=1, `lu_stall_cnt`=0.
- `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1 → 3 cycles with `pc_en`..`ex_mem_en`=0 and `mem_wb_flush`=1; 4th cycle defaults; `mem_wait_cnt`=3; `mem_err`=0.
- `halt_req` pulse with a 2-cycle freeze injected during DRAIN → `halted`=1 on the 6th edge after `halt_req`; all enables 0 thereafter; `branch_taken` in HALTED has no effect.
- `MEM_TIMEOUT`=4, `freeze` held → `mem_err`=1 and `halted`=1 after the 4th freeze edge; `rst_n` low asynchronously mid-cycle → `mem_err`=0, RUN defaults immediately.
